// File: rtl/piso_pkg.sv
// piso_pkg: shared bit-order constants, occupancy states and length normalisation
package piso_pkg;
    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {EMPTY, SHIFT, SHIFT_HOLD} state_t;

    function automatic int norm_len(input int len, input int n);
        return (len == 0 || len > n) ? n : len;
    endfunction
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: shift register, bit counter and first/last flags for one word
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  data,
    input  logic [LW-1:0] len,
    input  logic          msb_first,
    input  logic          take,
    output logic          bit_out,
    output logic          valid,
    output logic          first,
    output logic          last
);
    logic [N-1:0]  sh;
    logic [LW-1:0] idx;
    logic [LW-1:0] len_q;
    logic          msb_q;

    // MSB-first words are left-aligned so the outgoing bit is always sh[N-1]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            idx   <= '0;
            len_q <= '0;
            msb_q <= LSB_FIRST;
            valid <= 1'b0;
        end else if (load) begin
            sh    <= (msb_first == LSB_FIRST) ? data : data << (N - int'(len));
            idx   <= '0;
            len_q <= len;
            msb_q <= msb_first;
            valid <= 1'b1;
        end else if (valid && take) begin
            if (last) begin
                valid <= 1'b0;
                idx   <= '0;
            end else begin
                sh  <= (msb_q == MSB_FIRST) ? sh << 1 : sh >> 1;
                idx <= idx + LW'(1);
            end
        end
    end

    assign bit_out = valid && ((msb_q == MSB_FIRST) ? sh[N-1] : sh[0]);
    assign first   = valid && (idx == '0);
    assign last    = valid && (idx == len_q - LW'(1));
endmodule

// File: rtl/piso_stream.sv
// piso_stream: handshaked PISO serializer with a one-word holding buffer
module piso_stream
    import piso_pkg::*;
#(
    parameter  int N  = 8,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic [LW-1:0] in_len,
    input  logic          in_msb_first,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ser_out,
    output logic          ser_valid,
    input  logic          ser_ready,
    output logic          ser_first,
    output logic          ser_last
);
    state_t        state, state_nx;
    logic [N-1:0]  hold_data;
    logic [LW-1:0] hold_len;
    logic          hold_msb;
    logic [LW-1:0] in_len_n;
    logic          accept, done, load, hold_we, use_hold;

    assign in_len_n = LW'(norm_len(int'(in_len), N));
    assign accept   = in_valid && in_ready;
    assign done     = ser_valid && ser_ready && ser_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:      state_nx = accept ? SHIFT : EMPTY;
            SHIFT:      state_nx = done ? (accept ? SHIFT : EMPTY) : (accept ? SHIFT_HOLD : SHIFT);
            SHIFT_HOLD: state_nx = done ? SHIFT : SHIFT_HOLD;
            default:    state_nx = EMPTY;
        endcase
    end

    // held word always wins the shifter over a newly offered one
    always_comb begin
        in_ready = state != SHIFT_HOLD;
        use_hold = state == SHIFT_HOLD;
        load     = (state == EMPTY && accept) || (state == SHIFT && done && accept) ||
                   (state == SHIFT_HOLD && done);
        hold_we  = state == SHIFT && accept && !done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_len  <= '0;
            hold_msb  <= LSB_FIRST;
        end else if (hold_we) begin
            hold_data <= in_data;
            hold_len  <= in_len_n;
            hold_msb  <= in_msb_first;
        end
    end

    piso_shift_core #(.N(N), .LW(LW)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (use_hold ? hold_data : in_data),
        .len       (use_hold ? hold_len : in_len_n),
        .msb_first (use_hold ? hold_msb : in_msb_first),
        .take      (ser_ready),
        .bit_out   (ser_out),
        .valid     (ser_valid),
        .first     (ser_first),
        .last      (ser_last)
    );
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: directed vector table plus back-to-back, stall and mid-word reset sequences
module tb_piso_stream;
    import piso_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       msb;
        int         n;
        logic [7:0] bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] in_len = '0;
    logic       in_msb_first = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, ser_valid, ser_first, ser_last;
    logic       ser_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    vec_t tv[7];

    logic [7:0]  bw[3] = '{8'hA5, 8'h3C, 8'hF0};
    logic        bm[3] = '{1'b0, 1'b1, 1'b0};
    int          w, nv, fv, lv;
    logic        acc, saw_low, any_valid;
    logic [23:0] got;

    piso_stream #(.N(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_msb_first (in_msb_first),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_first    (ser_first),
        .ser_last     (ser_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // entered and left on a negedge with the block idle
    task automatic run_vec(input vec_t v, input int k);
        in_data = v.data;
        in_len = v.len;
        in_msb_first = v.msb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            check($sformatf("vec%0d bit%0d {valid,out,first,last}", k, i),
                  {ser_valid, ser_out, ser_first, ser_last},
                  {1'b1, v.bits[i], i == 0, i == v.n - 1});
            @(negedge clk);
        end
        check($sformatf("vec%0d idle after word", k), {ser_valid, ser_out, ser_first, ser_last}, 4'b0000);
    endtask

    initial begin
        tv[0] = '{data: 8'hB4, len: 4'd8,  msb: LSB_FIRST, n: 8, bits: 8'hB4};
        tv[1] = '{data: 8'hF3, len: 4'd5,  msb: MSB_FIRST, n: 5, bits: 8'h19};
        tv[2] = '{data: 8'hF3, len: 4'd0,  msb: MSB_FIRST, n: 8, bits: 8'hCF};
        tv[3] = '{data: 8'hB4, len: 4'd8,  msb: MSB_FIRST, n: 8, bits: 8'h2D};
        tv[4] = '{data: 8'h01, len: 4'd1,  msb: MSB_FIRST, n: 1, bits: 8'h01};
        tv[5] = '{data: 8'hC5, len: 4'd12, msb: LSB_FIRST, n: 8, bits: 8'hC5};
        tv[6] = '{data: 8'h96, len: 4'd3,  msb: LSB_FIRST, n: 3, bits: 8'h06};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset {valid,out,first,last,in_ready}",
              {ser_valid, ser_out, ser_first, ser_last, in_ready}, 5'b00001);
        check("reset state", dut.state, EMPTY);

        for (int k = 0; k < 7; k++) run_vec(tv[k], k);

        // back-to-back: three words offered continuously
        w = 0; nv = 0; fv = -1; lv = -1; acc = 1'b0; saw_low = 1'b0; got = '0;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if (acc) w++;
            if (ser_valid) begin
                if (nv < 24) got[nv] = ser_out;
                nv++;
                if (fv < 0) fv = c;
                lv = c;
            end
            if (!in_ready) saw_low = 1'b1;
            in_valid = w < 3;
            if (w < 3) begin
                in_data = bw[w];
                in_len = 4'd8;
                in_msb_first = bm[w];
            end
            acc = in_valid && in_ready;
        end
        in_valid = 1'b0;
        check("b2b valid bit count", nv, 24);
        check("b2b contiguous span", lv - fv + 1, 24);
        check("b2b bit stream", got, {8'hF0, 8'h3C, 8'hA5});
        check("b2b in_ready low while held", saw_low, 1'b1);

        // stall at bit 4 for 3 cycles
        @(negedge clk);
        in_data = 8'hB4; in_len = 4'd8; in_msb_first = LSB_FIRST; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stall bit%0d", i), {ser_valid, ser_out, ser_first, ser_last},
                  {1'b1, tv[0].bits[i], i == 0, i == 7});
            if (i == 3) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check($sformatf("stall frozen cycle%0d", s), {ser_valid, ser_out, ser_first, ser_last},
                          {1'b1, tv[0].bits[3], 1'b0, 1'b0});
                end
                ser_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("stall idle after word", ser_valid, 1'b0);

        // mid-word reset with a held word
        in_data = 8'hFF; in_len = 4'd8; in_msb_first = LSB_FIRST; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        check("hold full in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("pre-reset bit3 valid", {ser_valid, ser_out}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", {ser_valid, ser_out, ser_first, ser_last, in_ready}, 5'b00001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset release", {ser_valid, in_ready}, 2'b01);
        run_vec('{data: 8'h0F, len: 4'd4, msb: LSB_FIRST, n: 4, bits: 8'h0F}, 7);
        any_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ser_valid) any_valid = 1'b1;
        end
        check("discarded held word absent", any_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
